// File: rtl/xs3_bcd_decoder_if.sv
// rtl/xs3_bcd_decoder_if.sv - valid/ready handshake bundle for the Excess-3 to BCD decoder
interface xs3_bcd_decoder_if #(
    parameter int DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   in_xs3;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [DIGITS-1:0]     err_mask;

    modport master (
        output in_valid, in_xs3, out_ready,
        input  in_ready, out_valid, out_bcd, err_mask
    );

    modport slave (
        input  in_valid, in_xs3, out_ready,
        output in_ready, out_valid, out_bcd, err_mask
    );
endinterface

// File: rtl/xs3_bcd_decoder.sv
// rtl/xs3_bcd_decoder.sv - digit-serial Excess-3 to BCD decoder, LSD first, with per-digit invalid mask
module xs3_bcd_decoder #(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    xs3_bcd_decoder_if.slave    bus
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      sh;
    logic [W-1:0]      res;
    logic [DIGITS-1:0] err;

    logic [3:0]        code;
    logic [4:0]        sum;
    logic              bad;
    logic [3:0]        dig;
    logic              last;
    logic              accept;

    // Minus 3 as a 4-bit add of 1101; no carry-out means the code was below 3.
    assign code = sh[3:0];
    assign sum  = {1'b0, code} + 5'b01101;
    assign bad  = ~sum[4] | (code > 4'd12);
    assign dig  = bad ? 4'hF : sum[3:0];

    assign last   = (cnt == CW'(DIGITS - 1));
    assign accept = (state == IDLE) && bus.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.in_valid)  state_nxt = CONV;
            CONV: if (last)          state_nxt = DONE;
            DONE: if (bus.out_ready) state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sh  <= '0;
            res <= '0;
            err <= '0;
        end else if (accept) begin
            cnt <= '0;
            sh  <= bus.in_xs3;
            res <= '0;
            err <= '0;
        end else if (state == CONV) begin
            res[cnt*4 +: 4] <= dig;
            err[cnt]        <= bad;
            sh              <= sh >> 4;
            if (!last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_bcd   = res;
    assign bus.err_mask  = err;
endmodule

// File: tb/tb_xs3_bcd_decoder.sv
// tb/tb_xs3_bcd_decoder.sv - self-checking bench for xs3_bcd_decoder (DIGITS=4)
module tb_xs3_bcd_decoder;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_q[$];
    logic [15:0] out_q[$];

    xs3_bcd_decoder_if #(.DIGITS(D)) bus ();

    xs3_bcd_decoder #(.DIGITS(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
        if (bus.out_valid && bus.out_ready) out_q.push_back(bus.out_bcd);
    end

    typedef struct {
        logic [15:0] xs3;
        logic [15:0] bcd;
        logic [3:0]  mask;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: each nibble is a decimal digit plus three; anything outside 3..12 is flagged.
    function automatic void ref_dec(input logic [15:0] w, output logic [15:0] bcd, output logic [3:0] m);
        bcd = '0;
        m   = '0;
        for (int i = 0; i < D; i++) begin
            int v;
            v = (w >> (4 * i)) & 15;
            if (v < 3 || v > 12) begin
                bcd = bcd | (16'hF << (4 * i));
                m[i] = 1'b1;
            end else begin
                bcd = bcd | (16'(v - 3) << (4 * i));
            end
        end
    endfunction

    task automatic accept(input logic [15:0] w);
        int t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_xs3   = w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_xs3   = 16'($urandom);
    endtask

    task automatic xfer(input logic [15:0] w, input int hold,
                        output logic [15:0] bcd, output logic [3:0] m, output int lat);
        bus.out_ready = 1'b0;
        accept(w);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bcd = bus.out_bcd;
        m   = bus.err_mask;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        vec_t        vt[5];
        logic [15:0] bcd, ebcd, sb;
        logic [3:0]  m, em, sm;
        logic [15:0] words[3];
        logic [15:0] exps[3];
        int          lat, a0, o0, t;

        bus.in_valid  = 1'b0;
        bus.in_xs3    = '0;
        bus.out_ready = 1'b0;

        vt[0] = '{16'h4A7C, 16'h1749, 4'b0000};
        vt[1] = '{16'h3333, 16'h0000, 4'b0000};
        vt[2] = '{16'hCCCC, 16'h9999, 4'b0000};
        vt[3] = '{16'h3F23, 16'h0FF0, 4'b0110};
        vt[4] = '{16'h0000, 16'hFFFF, 4'b1111};

        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_bcd", 32'(bus.out_bcd), 32'd0);
        chk("rst_err_mask", 32'(bus.err_mask), 32'd0);
        rst_n = 1'b1;

        foreach (vt[i]) begin
            xfer(vt[i].xs3, 0, bcd, m, lat);
            chk("vec_latency", 32'(lat), 32'd4);
            chk("vec_bcd", 32'(bcd), 32'(vt[i].bcd));
            chk("vec_mask", 32'(m), 32'(vt[i].mask));
        end

        for (int i = 0; i < 20; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            ref_dec(w, ebcd, em);
            xfer(w, $urandom_range(0, 3), bcd, m, lat);
            chk("rnd_latency", 32'(lat), 32'd4);
            chk("rnd_bcd", 32'(bcd), 32'(ebcd));
            chk("rnd_mask", 32'(m), 32'(em));
        end

        // Backpressure with a competing word offered while the result is held.
        bus.out_ready = 1'b0;
        accept(16'h3F23);
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        sb = bus.out_bcd;
        sm = bus.err_mask;
        chk("bp_bcd", 32'(sb), 32'h0FF0);
        chk("bp_mask", 32'(sm), 32'b0110);
        bus.in_valid = 1'b1;
        bus.in_xs3   = 16'hCCCC;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_bcd", 32'(bus.out_bcd), 32'(sb));
            chk("bp_hold_mask", 32'(bus.err_mask), 32'(sm));
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_not_captured", 32'(bus.in_ready), 32'd1);

        // Back-to-back streaming.
        words = '{16'h4A7C, 16'h5B6B, 16'h3C3C};
        exps  = '{16'h1749, 16'h2838, 16'h0909};
        a0 = acc_q.size();
        o0 = out_q.size();
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_xs3 = words[i];
            t = 0;
            while (acc_q.size() == a0 + i && t < 30) begin
                @(posedge clk);
                #1;
                t++;
            end
            chk("b2b_accept", 32'(acc_q.size()), 32'(a0 + i + 1));
        end
        bus.in_valid = 1'b0;
        t = 0;
        while (out_q.size() < o0 + 3 && t < 40) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("b2b_out_count", 32'(out_q.size()), 32'(o0 + 3));
        if (out_q.size() >= o0 + 3 && acc_q.size() >= a0 + 3) begin
            for (int i = 0; i < 3; i++) chk("b2b_bcd", 32'(out_q[o0 + i]), 32'(exps[i]));
            chk("b2b_spacing1", 32'(acc_q[a0 + 1] - acc_q[a0]), 32'd6);
            chk("b2b_spacing2", 32'(acc_q[a0 + 2] - acc_q[a0 + 1]), 32'd6);
        end

        // Reset pulse after two CONV cycles discards the word.
        o0 = out_q.size();
        accept(16'h4A7C);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_rst_no_output", 32'(out_q.size()), 32'(o0));
        chk("mid_rst_idle", 32'(bus.in_ready), 32'd1);
        xfer(16'h3333, 0, bcd, m, lat);
        chk("after_rst_latency", 32'(lat), 32'd4);
        chk("after_rst_bcd", 32'(bcd), 32'h0000);
        chk("after_rst_mask", 32'(m), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
